// File: rtl/ascon_pack.sv
// Shared types, constants and helpers for the Ascon permutation core.
package ascon_pack;

    localparam int ROUNDS_FULL_C  = 12;
    localparam int ROUNDS_SHORT_C = 6;

    // Five 64-bit words; index 0 is x0 and sits in the most significant bits.
    typedef logic [0:4][63:0] type_state;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Round constant for round index r: upper nibble 15-r, lower nibble r.
    function automatic logic [7:0] round_constant(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    // 64-bit rotate right.
    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/permutation_core_round_comb.sv
// One full combinational Ascon round: constant addition, S-box layer, linear layer.
module round_comb
    import ascon_pack::*;
(
    input  type_state   state_i,
    input  logic [3:0]  round_i,
    output type_state   state_o
);

    // Constant addition into the low byte of x2.
    function automatic type_state pc(input type_state s, input logic [3:0] r);
        type_state t;
        t = s;
        t[2][7:0] = t[2][7:0] ^ round_constant(r);
        return t;
    endfunction

    // Bitsliced 5-bit S-box applied to all 64 columns at once.
    function automatic type_state ps(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    // Per-word linear diffusion.
    function automatic type_state pl(input type_state s);
        type_state t;
        t[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        t[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        t[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
        t[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        t[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
        return t;
    endfunction

    // Chain the three layers into one round.
    always_comb begin
        state_o = pl(ps(pc(state_i, round_i)));
    end

endmodule

// File: rtl/permutation_core.sv
// Iterative Ascon permutation: one round per clock, p^a or p^b selected at start.
module permutation_core
    import ascon_pack::*;
#(
    parameter int ROUNDS_FULL  = 12,
    parameter int ROUNDS_SHORT = 6
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  logic      mode_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam logic [3:0] FIRST_FULL  = 4'(ROUNDS_FULL_C - ROUNDS_FULL);
    localparam logic [3:0] FIRST_SHORT = 4'(ROUNDS_FULL_C - ROUNDS_SHORT);
    localparam logic [3:0] LAST_ROUND  = 4'(ROUNDS_FULL_C - 1);

    fsm_t       fsm_q;
    logic [3:0] round_q;
    type_state  state_q;
    type_state  state_d;
    logic       done_q;

    round_comb u_round (
        .state_i (state_q),
        .round_i (round_q),
        .state_o (state_d)
    );

    // FSM, round counter, state register and done pulse.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= state_i;
                        round_q <= mode_i ? FIRST_FULL : FIRST_SHORT;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    // The counter parks at the last index instead of wrapping.
                    if (round_q == LAST_ROUND) begin
                        fsm_q  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == RUN);
    assign done_o  = done_q;

endmodule
